// File: rtl/microprocessor_mult_pkg.sv
// Shared encodings and helpers for the pipelined CPU multiplier.
package microprocessor_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mult_op_e;

    // Returns {sa, sb}: whether operand A / operand B is treated as signed.
    function automatic logic [1:0] op_signs(mult_op_e op);
        logic sa;
        logic sb;
        sa = (op == OP_MULXSU) || (op == OP_MULXSS);
        sb = (op == OP_MULXSS);
        return {sa, sb};
    endfunction

endpackage

// File: rtl/microprocessor_cpu_mult_pp.sv
// Registered unsigned Width x Width partial-product multiplier (one DSP slice).
module microprocessor_cpu_mult_pp #(
    parameter int unsigned Width = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] p_o
);

    logic [2*Width-1:0] p_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= (2*Width)'(a_i) * (2*Width)'(b_i);
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/microprocessor_cpu_mult_pipe.sv
// Two-stage pipelined WIDTH x WIDTH multiplier with valid/ready handshake,
// tag passthrough and synchronous flush.
module microprocessor_cpu_mult_pipe
    import microprocessor_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned H = WIDTH / 2;

    logic             v1_q, v1_d, v2_q, v2_d;
    logic             s1_adv, s2_adv, s1_load, s2_load;
    logic [1:0]       op1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [WIDTH-1:0] corr_q, corr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] p_ll, p_lh, p_hl, p_hh;
    logic [2*WIDTH-1:0] prod;
    logic [1:0]       signs;

    assign s2_adv   = !v2_q || out_ready;
    assign s1_adv   = !v1_q || s2_adv;
    assign in_ready = s1_adv;
    // An input offered in a flush cycle is dropped even though in_ready is high.
    assign s1_load  = in_valid && s1_adv && !flush;
    assign s2_load  = s2_adv && v1_q;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (s2_adv) v2_d = v1_q;
            if (s1_adv) v1_d = in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Two's-complement correction turning the unsigned high word into the signed one.
    always_comb begin
        signs  = op_signs(mult_op_e'(in_op));
        corr_d = (signs[1] && in_src1[WIDTH-1]) ? in_src2 : '0;
        if (signs[0] && in_src2[WIDTH-1]) corr_d = corr_d + in_src1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1_q  <= '0;
            tag1_q <= '0;
            corr_q <= '0;
        end else if (s1_load) begin
            op1_q  <= in_op;
            tag1_q <= in_tag;
            corr_q <= corr_d;
        end
    end

    microprocessor_cpu_mult_pp #(.Width(H)) u_pp_ll (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (s1_load),
        .a_i   (in_src1[H-1:0]),
        .b_i   (in_src2[H-1:0]),
        .p_o   (p_ll)
    );

    microprocessor_cpu_mult_pp #(.Width(H)) u_pp_lh (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (s1_load),
        .a_i   (in_src1[H-1:0]),
        .b_i   (in_src2[WIDTH-1:H]),
        .p_o   (p_lh)
    );

    microprocessor_cpu_mult_pp #(.Width(H)) u_pp_hl (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (s1_load),
        .a_i   (in_src1[WIDTH-1:H]),
        .b_i   (in_src2[H-1:0]),
        .p_o   (p_hl)
    );

    microprocessor_cpu_mult_pp #(.Width(H)) u_pp_hh (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (s1_load),
        .a_i   (in_src1[WIDTH-1:H]),
        .b_i   (in_src2[WIDTH-1:H]),
        .p_o   (p_hh)
    );

    always_comb begin
        prod = (2*WIDTH)'(p_ll)
             + ((2*WIDTH)'(p_lh) << H)
             + ((2*WIDTH)'(p_hl) << H)
             + {p_hh, {WIDTH{1'b0}}};
        if (op1_q == OP_MUL) begin
            result_d = prod[WIDTH-1:0];
        end else begin
            result_d = prod[2*WIDTH-1:WIDTH] - corr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            tag2_q   <= '0;
        end else if (s2_load) begin
            result_q <= result_d;
            tag2_q   <= tag1_q;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = result_q;
    assign out_tag    = tag2_q;

endmodule

// File: tb/tb_microprocessor_cpu_mult_pipe.sv
// Self-checking bench: directed vectors plus a queue-based reference model.
module tb_microprocessor_cpu_mult_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int tests = 0;
    int failed = 0;
    int n_out = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];

    microprocessor_cpu_mult_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: extend each operand per its signedness, take a full 64-bit product.
    function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b10 || op == 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    // Scoreboard: compare every valid output against the model queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL mon_unexpected: got output tag %0d required no output", out_tag);
                end else begin
                    check("mon_result", out_result, q[0].res);
                    check("mon_tag", 32'(out_tag), 32'(q[0].tag));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{model(in_op, in_src1, in_src2), in_tag});
        end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: got in_ready 0 required 1 within 50 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        drive(op, a, b, tag);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start_out;
        int n;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("mul_small", 2'b00, 32'h0001_0003, 32'h0002_0005, 5'd1, 32'h000B_000F);
        run_one("mulxuu_small", 2'b01, 32'h0001_0003, 32'h0002_0005, 5'd2, 32'h0000_0002);
        run_one("mulxuu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        run_one("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
        run_one("mulxss_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000);
        run_one("mulxss_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
        run_one("mulxsu_neg", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 5'd7, 32'hFFFF_FFFF);

        // Backpressure: four ops with the consumer stalled.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start_out = n_out;
        drive(2'b00, 32'd3, 32'd5, 5'd1);
        wait_accept("bp_t1");
        drive(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd2);
        wait_accept("bp_t2");
        drive(2'b11, 32'hFFFF_FFFF, 32'd2, 5'd3);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_tag", 32'(out_tag), 32'd1);
            check("bp_hold_result", out_result, 32'd15);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp_t3");
        drive(2'b10, 32'h8000_0000, 32'h8000_0000, 5'd4);
        wait_accept("bp_t4");
        in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_drain_count", 32'(n_out - start_out), 32'd4);
        check("bp_queue_empty", 32'(q.size()), 32'd0);

        // Flush with two ops in flight plus an input offered in the flush cycle.
        drive(2'b00, 32'd6, 32'd7, 5'd10);
        wait_accept("fl_a");
        drive(2'b00, 32'd8, 32'd9, 5'd11);
        wait_accept("fl_b");
        flush = 1'b1;
        drive(2'b00, 32'd2, 32'd2, 5'd12);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("fl_dropped", 32'(out_valid), 32'd0);
        end
        run_one("fl_after", 2'b01, 32'h0001_0003, 32'h0002_0005, 5'd13, 32'h0000_0002);

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        drive(2'b00, 32'd11, 32'd13, 5'd20);
        @(posedge clk);
        #1;
        drive(2'b00, 32'd17, 32'd19, 5'd21);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        in_valid = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", out_result, 32'd0);
        check("rst_mid_tag", 32'(out_tag), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("rst_rel_in_ready", 32'(in_ready), 32'd1);
        check("rst_rel_valid", 32'(out_valid), 32'd0);
        run_one("rst_after", 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd22, 32'h4000_0000);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
